// File: rtl/down_count_timer_pkg.sv
// Shared timer definitions: FSM state encoding and default counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package timer_pkg;

    localparam int unsigned TIMER_WIDTH_DEFAULT = 8;

    // Two-bit state encoding shared with future timers in the subsystem.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        EXPIRE = 2'd3
    } timer_state_e;

endpackage

// File: rtl/down_count_timer_reload_reg.sv
// Reload value register with write enable, reusable by other timers.
// Latency: a write is visible on o_q the cycle after i_we.
// Backpressure: none; every enabled write is taken.
module reload_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture the new reload value on a write; async clear on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counting timer with terminal-count pulse and optional auto-reload.
// Latency: load visible next cycle; first decrement one edge after entering RUN.
// Backpressure: load accepted only while load_ready (IDLE/HOLD); dropped otherwise.
module down_count_timer
    import timer_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic             count,
    output logic [WIDTH-1:0] data_o,
    output logic             tc,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    timer_state_e     r_state;
    logic [WIDTH-1:0] r_data;

    timer_state_e     w_next_state;
    logic [WIDTH-1:0] w_next_data;
    logic             w_reload_we;
    logic [WIDTH-1:0] w_reload;
    logic             w_data_zero;
    logic             w_reload_zero;

    assign w_data_zero   = (r_data == '0);
    assign w_reload_zero = (w_reload == '0);

    // Every accepted load also refreshes the reload register.
    reload_reg #(
        .WIDTH (WIDTH)
    ) u_reload_reg (
        .clock (clock),
        .reset (reset),
        .i_we  (w_reload_we),
        .i_d   (load_value),
        .o_q   (w_reload)
    );

    // Next-state and next-count decode; stop beats count in RUN, load beats start.
    always_comb begin
        w_next_state = r_state;
        w_next_data  = r_data;
        w_reload_we  = 1'b0;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_next_data = load_value;
                    w_reload_we = 1'b1;
                end else if (start && !w_data_zero) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    w_next_state = HOLD;
                end else if (count) begin
                    // The 1->0 step always leaves RUN, so the count cannot wrap.
                    if (r_data <= ONE) begin
                        w_next_data  = '0;
                        w_next_state = EXPIRE;
                    end else begin
                        w_next_data = r_data - ONE;
                    end
                end
            end
            HOLD: begin
                if (load) begin
                    w_next_data = load_value;
                    w_reload_we = 1'b1;
                    if (load_value == '0) begin
                        w_next_state = IDLE;
                    end
                end else if (start) begin
                    w_next_state = w_data_zero ? IDLE : RUN;
                end
            end
            EXPIRE: begin
                if (auto_reload && !w_reload_zero) begin
                    w_next_data  = w_reload;
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
        endcase
    end

    // State and counter registers; reset clears them without waiting for an edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            r_data  <= w_next_data;
        end
    end

    // Status flags come from the registered state only.
    always_comb begin
        tc         = (r_state == EXPIRE);
        busy       = (r_state == RUN) || (r_state == EXPIRE);
        load_ready = (r_state == IDLE) || (r_state == HOLD);
    end

    assign data_o = r_data;

endmodule

// File: tb/tb_down_count_timer.sv
// Randomized plus directed bench for down_count_timer with a scoreboard.
// Latency: expected values are queued at the input edge and popped after the clock edge.
// Backpressure: n/a.
module tb_down_count_timer;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         auto_reload = 1'b0;
    logic         count = 1'b0;
    logic         load_ready;
    logic [W-1:0] data_o;
    logic         tc;
    logic         busy;

    always #5 clock = ~clock;

    down_count_timer #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .load_ready  (load_ready),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .count       (count),
        .data_o      (data_o),
        .tc          (tc),
        .busy        (busy)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         tc;
        logic         busy;
        logic         lr;
    } exp_t;

    typedef enum int {M_IDLE, M_RUN, M_HOLD, M_EXP} mode_t;

    mode_t        m_mode;
    logic [W-1:0] m_val;
    logic [W-1:0] m_rel;
    exp_t         sb_q[$];
    int           n_checks = 0;
    int           n_pass = 0;
    int           tc_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: timer behaviour written straight from the rules.
    task automatic model_reset();
        m_mode = M_IDLE;
        m_val  = '0;
        m_rel  = '0;
    endtask

    task automatic model_step(input logic ld, input logic [W-1:0] lv, input logic st,
                              input logic sp, input logic ar, input logic cn);
        case (m_mode)
            M_IDLE: begin
                if (ld) begin m_val = lv; m_rel = lv; end
                else if (st && m_val != 0) m_mode = M_RUN;
            end
            M_RUN: begin
                if (sp) m_mode = M_HOLD;
                else if (cn) begin
                    m_val = m_val - 1;
                    if (m_val == 0) m_mode = M_EXP;
                end
            end
            M_HOLD: begin
                if (ld) begin
                    m_val = lv; m_rel = lv;
                    if (lv == 0) m_mode = M_IDLE;
                end else if (st) m_mode = (m_val != 0) ? M_RUN : M_IDLE;
            end
            M_EXP: begin
                if (ar && m_rel != 0) begin m_val = m_rel; m_mode = M_RUN; end
                else m_mode = M_IDLE;
            end
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.data = m_val;
        e.tc   = (m_mode == M_EXP);
        e.busy = (m_mode == M_RUN) || (m_mode == M_EXP);
        e.lr   = (m_mode == M_IDLE) || (m_mode == M_HOLD);
        return e;
    endfunction

    // One cycle of stimulus: drive at the falling edge, queue the post-edge expectation.
    task automatic step(input logic ld, input logic [W-1:0] lv, input logic st,
                        input logic sp, input logic ar, input logic cn);
        @(negedge clock);
        load = ld; load_value = lv; start = st; stop = sp; auto_reload = ar; count = cn;
        model_step(ld, lv, st, sp, ar, cn);
        sb_q.push_back(model_out());
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset asserted between edges; outputs must clear before the next clock edge.
    task automatic async_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        load = 1'b0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0; count = 1'b0;
        #1;
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_flags", {29'd0, tc, busy, load_ready}, 32'b001);
        model_reset();
        sb_q.push_back(model_out());
        @(negedge clock);
        reset = 1'b1;
        model_step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_q.push_back(model_out());
    endtask

    task automatic direct(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    // Monitor: compare every post-edge sample with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (tc === 1'b1) tc_seen++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("cycle", {21'd0, data_o, tc, busy, load_ready},
                      {21'd0, e.data, e.tc, e.busy, e.lr});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
        $fatal(1);
    end

    initial begin
        int t0;
        model_reset();
        #2;
        reset = 1'b0;
        #1;
        direct("reset_data", 32'(data_o), 32'd0);
        direct("reset_flags", {29'd0, tc, busy, load_ready}, 32'b001);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // One-shot: 3,2,1,0 with a single tc, then back to idle.
        t0 = tc_seen;
        step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clock); #2;
        direct("oneshot_tc_now", {30'd0, tc, busy}, 32'b11);
        idle_cycles(3);
        @(posedge clock); #2;
        direct("oneshot_tc_count", 32'(tc_seen - t0), 32'd1);
        direct("oneshot_idle", {23'd0, data_o, busy}, 32'd0);

        // Auto-reload: period of 3 cycles, two pulses.
        t0 = tc_seen;
        step(1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clock); #2;
        direct("autoreload_tc_count", 32'(tc_seen - t0), 32'd2);
        direct("autoreload_busy", 32'(busy), 32'd1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(2);

        // Stop wins over count, HOLD accepts a reload, RUN ignores loads.
        async_reset();
        step(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock); #2;
        direct("run_ignores_load", {23'd0, data_o, load_ready}, {23'd0, 8'd7, 1'b0});
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clock); #2;
        direct("hold_stop_wins", {23'd0, data_o, load_ready}, {23'd0, 8'd7, 1'b1});
        step(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clock); #2;
        direct("hold_resume", 32'(data_o), 32'd7);

        // IDLE with zero value ignores start; load+start loads without running.
        async_reset();
        t0 = tc_seen;
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clock); #2;
        direct("load_start_same", {23'd0, data_o, busy}, {23'd0, 8'd4, 1'b0});
        direct("zero_start_no_tc", 32'(tc_seen - t0), 32'd0);

        // Async reset mid-run, then start from value 0 stays idle.
        step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        async_reset();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clock); #2;
        direct("post_reset_start", {23'd0, data_o, busy}, 32'd0);

        // Full-scale value counted down with count pulsed every other cycle.
        t0 = tc_seen;
        step(1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 520; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, (i % 2) == 0);
        @(posedge clock); #2;
        direct("width_tc_count", 32'(tc_seen - t0), 32'd1);
        direct("width_final", {23'd0, data_o, busy}, 32'd0);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 2500; i++) begin
            logic [W-1:0] lv;
            lv = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
            if ($urandom_range(0, 299) == 0) async_reset();
            else step($urandom_range(0, 9) == 0, lv, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 9) < 6);
        end
        idle_cycles(2);
        @(posedge clock); #2;
        direct("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/down_count_timer.md
Name: down_count_timer

Overview:
- Loadable down-counting timer: the counterpart of the team's 8-bit up counter (`data_o` / `count` style).
- Software or a controller loads a start value. The block decrements it on qualified `count` ticks and flags terminal count with a one-cycle pulse.
- Optional auto-reload for periodic operation.
- Sits beside the up counter in the timing subsystem. It is the consumer side: it times out intervals that the producer side measured or programmed.

Parameters:
- WIDTH, 8, bit width of the counter, load value and reload register (WIDTH >= 2).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Low clears all state immediately, independent of clock. Release is synchronous to clock in the parent.
- load  input  1  load request; accepted only when load_ready=1.
- load_value  input  WIDTH  value written to data_o and to the reload register on an accepted load.
- load_ready  output  1  high in IDLE and HOLD, low in RUN and EXPIRE.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- auto_reload  input  1  sampled in EXPIRE; selects periodic vs one-shot.
- count  input  1  decrement enable (tick qualifier).
- data_o  output  WIDTH  current counter value, registered.
- tc  output  1  terminal-count pulse, high for exactly the EXPIRE cycle.
- busy  output  1  high in RUN and EXPIRE.

Behaviour:
- Reset (reset=0):
  - state=IDLE, data_o=0, reload register=0.
  - tc=0, busy=0, load_ready=1 (decoded from IDLE).
  - Takes effect mid-operation without waiting for an edge.
- States:
  - IDLE:
    - Accepted load: data_o<=load_value and reload<=load_value; stay IDLE.
    - start with data_o!=0 and no load that cycle: go to RUN.
    - start with data_o==0: ignored, stay IDLE, no tc.
    - load and start in the same cycle: the load is applied, the start is ignored. A further start is needed.
  - RUN:
    - stop=1: go to HOLD; no decrement that cycle, even if count=1 (stop wins).
    - count=1 and data_o>1: data_o<=data_o-1.
    - count=1 and data_o==1: data_o<=0 and go to EXPIRE.
    - count=0: hold value.
    - load is ignored (load_ready=0); start is ignored.
  - HOLD:
    - data_o frozen; count ignored.
    - An accepted load updates data_o and reload; if load_value=0, go to IDLE.
    - start (no load, data_o!=0): go to RUN.
    - start with data_o==0: go to IDLE.
  - EXPIRE (exactly one cycle):
    - tc=1 and data_o=0.
    - auto_reload=1 and reload!=0: data_o<=reload and go to RUN.
    - Otherwise go to IDLE.
    - stop, count, load and start are ignored.
- Outputs:
  - tc, busy and load_ready are decoded from the registered state only (Moore); there is no combinational path from inputs.
  - tc is asserted during the cycle whose data_o first reads 0.
- Arithmetic:
  - Decrement is modulo-free: data_o never wraps below 0, because the 1->0 transition always exits RUN.
  - A load value of 2^WIDTH-1 is legal.
- Latency:
  - Accepted load is visible on data_o the next cycle.
  - start in IDLE: the first decrement can occur on the edge after entering RUN.
  - Period with auto-reload and count tied high = reload+1 cycles (reload RUN cycles plus 1 EXPIRE cycle).

Decomposition:
- Shared package timer_pkg:
  - state enum {IDLE, RUN, HOLD, EXPIRE} (2-bit encoding).
  - default WIDTH constant.
- No sub-module required. Counter datapath, reload register and FSM fit in one module.
- Optional sub-module reload_reg (WIDTH-bit register with write enable and async active-low clear) if the team wants it shared with future timers.

Test Plan:
- One-shot: load 3, start, count=1 continuously -> data_o 3,2,1,0; tc=1 only in the cycle data_o=0; next cycle IDLE, data_o stays 0, busy=0.
- Auto-reload: auto_reload=1, load 2, start, count=1 -> data_o 2,1,0(tc),2,1,0(tc); tc period 3 cycles; busy stays 1.
- Stop priority and HOLD:
  - load 10, start, 3 counts -> data_o=7.
  - Assert stop with count=1 -> data_o stays 7, state HOLD, load_ready=1.
  - load 9 -> data_o=9; start -> RUN, decrements from 9.
- Ignored inputs:
  - In RUN, load 200 -> data_o unaffected, load_ready=0.
  - In IDLE with data_o=0, start -> stays IDLE, no tc.
  - load and start in the same cycle -> load applied, no RUN.
- Async reset mid-run: load 5, start, 2 counts (data_o=3), drive reset=0 between clock edges -> data_o=0, busy=0, tc=0 immediately. After release, start -> stays IDLE (value 0).
- Width boundary: WIDTH=8, load 255, count pulsed every other cycle -> reaches 0 after 255 counts with no wrap, exactly one tc.
